// File: rtl/serial_pkg.sv
// Shared types and line-level constants for the serial word transmitter.
// Also provides a helper that sizes counters so they are never zero bits wide.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_word_tx_bit_timer.sv
// Bit-period timer: counts CLKS_PER_BIT clocks per serial bit and flags the last one.
// The count restarts on clear and wraps to zero at the end of every bit period.
module bit_timer
  import serial_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic bit_end
);

  localparam int unsigned CNT_W = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] clk_cnt_q;
  logic [CNT_W-1:0] clk_cnt_d;

  // With a single clock per bit the count sits at zero and bit_end stays high.
  assign bit_end = (clk_cnt_q == LAST_CNT);

  always_comb begin
    clk_cnt_d = clk_cnt_q;
    if (clear) begin
      clk_cnt_d = '0;
    end else if (run) begin
      clk_cnt_d = bit_end ? '0 : clk_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_cnt_q <= '0;
    end else begin
      clk_cnt_q <= clk_cnt_d;
    end
  end

endmodule

// File: rtl/serial_word_tx.sv
// Parallel-in serial-out transmitter: start bit, WIDTH data bits LSB first, stop bit.
// tx, busy and done are registered from the next-state view so they change only on edges.
module serial_word_tx
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH        = 4,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] data_in,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  localparam int unsigned BIT_W = cnt_width(WIDTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept;
  logic             bit_end;

  assign load_ready = (state_q == IDLE) && !reset;
  assign accept     = load_valid && load_ready;

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .run    (state_q != IDLE),
    .bit_end(bit_end)
  );

  // Frame sequencing; outputs derive from the upcoming state so they line up with it.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    done_d    = 1'b0;
    tx_d      = IDLE_LEVEL;

    case (state_q)
      IDLE: begin
        if (accept) begin
          shift_d   = data_in;
          bit_cnt_d = '0;
          state_d   = START;
        end
      end
      START: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LAST_BIT) begin
            state_d = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   tx_d = START_BIT;
      DATA:    tx_d = shift_d[0];
      STOP:    tx_d = STOP_BIT;
      default: tx_d = IDLE_LEVEL;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= IDLE_LEVEL;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
